// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: ramped, dead-timed H-bridge drive for a two-wheel base with shared PWM and per-wheel direction.
module motor_drive_ctrl #(
  parameter int MAX_DUTY = 200,
  parameter int STEP     = 10,
  parameter int RAMP_DIV = 1000,
  parameter int DEAD_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       motor_fwd,
  input  logic       motor_bwd,
  input  logic       motor_left,
  input  logic       motor_right,
  input  logic       motor_stop,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic [7:0] duty,
  output logic [2:0] drv_state,
  output logic       busy
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    DEAD      = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [15:0] presc;
  logic [7:0]  pwm_cnt, dead_cnt, dead_cnt_n, duty_n, up_sat, down;
  logic [8:0]  up;
  logic [2:0]  n_cmd;
  logic        dir_l_n, dir_r_n, pwm_n;
  logic        active, hard, tdir_l, tdir_r, same, tick;

  assign drv_state = state;
  assign n_cmd     = 3'(motor_fwd) + 3'(motor_bwd) + 3'(motor_left) + 3'(motor_right);
  assign active    = |{motor_fwd, motor_bwd, motor_left, motor_right};
  assign hard      = motor_stop | (n_cmd > 3'd1);
  assign tdir_l    = motor_fwd | motor_right;
  assign tdir_r    = motor_fwd | motor_left;
  assign same      = {tdir_l, tdir_r} == {dir_l, dir_r};
  assign tick      = presc == 16'(RAMP_DIV - 1);
  assign up        = {1'b0, duty} + 9'(STEP);
  assign up_sat    = (up >= 9'(MAX_DUTY)) ? 8'(MAX_DUTY) : up[7:0];
  assign down      = (duty > 8'(STEP)) ? duty - 8'(STEP) : 8'd0;
  // A hard stop blanks the bridge on the same edge that enters DEAD.
  assign pwm_n     = (pwm_cnt < duty) && !(hard && state != DEAD);

  always_comb begin
    state_n    = state;
    duty_n     = duty;
    dir_l_n    = dir_l;
    dir_r_n    = dir_r;
    dead_cnt_n = dead_cnt;
    if (hard && state != DEAD) begin
      state_n    = DEAD;
      duty_n     = 8'd0;
      dead_cnt_n = 8'd0;
    end else begin
      case (state)
        IDLE: if (active) begin
          state_n = RAMP_UP;
          dir_l_n = tdir_l;
          dir_r_n = tdir_r;
        end
        RAMP_UP: begin
          if (!active || !same) state_n = RAMP_DOWN;
          else if (duty == 8'(MAX_DUTY)) state_n = RUN;
          else if (tick) duty_n = up_sat;
        end
        RUN: begin
          duty_n = 8'(MAX_DUTY);
          if (!active || !same) state_n = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (active && same) state_n = RAMP_UP;
          else if (duty == 8'd0) begin
            state_n    = DEAD;
            dead_cnt_n = 8'd0;
          end else if (tick) duty_n = down;
        end
        DEAD: begin
          duty_n     = 8'd0;
          dead_cnt_n = hard ? 8'd0 : dead_cnt + 8'd1;
          if (!hard && dead_cnt == 8'(DEAD_CYC - 1)) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          duty_n  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      duty     <= 8'd0;
      dir_l    <= 1'b1;
      dir_r    <= 1'b1;
      pwm_l    <= 1'b0;
      pwm_r    <= 1'b0;
      busy     <= 1'b0;
      presc    <= 16'd0;
      pwm_cnt  <= 8'd0;
      dead_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      duty     <= duty_n;
      dir_l    <= dir_l_n;
      dir_r    <= dir_r_n;
      pwm_l    <= pwm_n;
      pwm_r    <= pwm_n;
      busy     <= state_n != IDLE;
      presc    <= tick ? 16'd0 : presc + 16'd1;
      pwm_cnt  <= pwm_cnt + 8'd1;
      dead_cnt <= dead_cnt_n;
    end
  end
endmodule

// File: tb/tb_motor_drive_ctrl.sv
// tb_motor_drive_ctrl: table vectors, directed corner sequences and random commands against a reference model.
module tb_motor_drive_ctrl;
  localparam int MAXD = 200, STP = 50, DIV = 4, DEADC = 3;

  logic clk = 1'b0;
  bit rst = 1'b1, fwd, bwd, left, right, stop;
  logic pwm_l, pwm_r, dir_l, dir_r, busy;
  logic [7:0] duty;
  logic [2:0] drv_state;
  int n_cmp = 0, n_bad = 0;

  motor_drive_ctrl #(.MAX_DUTY(MAXD), .STEP(STP), .RAMP_DIV(DIV), .DEAD_CYC(DEADC)) dut (
    .clk(clk), .rst(rst), .motor_fwd(fwd), .motor_bwd(bwd), .motor_left(left),
    .motor_right(right), .motor_stop(stop), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .dir_l(dir_l), .dir_r(dir_r), .duty(duty), .drv_state(drv_state), .busy(busy)
  );

  always #5 clk = ~clk;

  int m_st, m_du, m_dl, m_dr, m_pr, m_pc, m_dc;
  bit m_pw, m_busy;
  logic [7:0] prev_duty;
  logic prev_dl, prev_dr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level model: counts elapsed dead cycles, uses plain integer min/max ramping.
  task automatic model_step();
    int n, tl, tr;
    bit act, hard, same, tick;
    n = int'(fwd) + int'(bwd) + int'(left) + int'(right);
    act = n > 0;
    hard = stop || n > 1;
    tl = int'(fwd | right);
    tr = int'(fwd | left);
    if (rst) begin
      m_st = 0; m_du = 0; m_dl = 1; m_dr = 1; m_pr = 0; m_pc = 0; m_dc = 0; m_pw = 0;
    end else begin
      m_pw = (m_pc < m_du) && !(hard && m_st != 4);
      tick = m_pr == DIV - 1;
      m_pr = (m_pr + 1) % DIV;
      m_pc = (m_pc + 1) % 256;
      same = (tl == m_dl) && (tr == m_dr);
      if (hard && m_st != 4) begin
        m_st = 4; m_du = 0; m_dc = 0;
      end else if (m_st == 4) begin
        if (hard) m_dc = 0;
        else begin
          m_dc++;
          if (m_dc == DEADC) m_st = 0;
        end
      end else if (m_st == 0) begin
        if (act) begin m_st = 1; m_dl = tl; m_dr = tr; end
      end else if ((m_st == 1 || m_st == 2) && !(act && same)) m_st = 3;
      else if (m_st == 1) begin
        if (m_du == MAXD) m_st = 2;
        else if (tick) m_du = (m_du + STP > MAXD) ? MAXD : m_du + STP;
      end else if (m_st == 3) begin
        if (act && same) m_st = 1;
        else if (m_du == 0) begin m_st = 4; m_dc = 0; end
        else if (tick) m_du = (m_du - STP < 0) ? 0 : m_du - STP;
      end
    end
    m_busy = m_st != 0;
  endtask

  task automatic cyc();
    prev_duty = duty; prev_dl = dir_l; prev_dr = dir_r;
    @(posedge clk);
    model_step();
    #1;
    chk("outputs", {drv_state, duty, dir_l, dir_r, pwm_l, pwm_r, busy},
        {3'(m_st), 8'(m_du), 1'(m_dl), 1'(m_dr), m_pw, m_pw, m_busy});
    chk("pwm_equal", pwm_l, pwm_r);
    if (!rst && {dir_l, dir_r} !== {prev_dl, prev_dr}) chk("dir_change_at_zero", prev_duty, 0);
  endtask

  task automatic set_in(input bit [5:0] v);
    {fwd, bwd, left, right, stop, rst} = v;
  endtask

  task automatic wait_for(input string nm, input int st, input int du, input int budget);
    int k = 0;
    while (!(drv_state == 3'(st) && (du < 0 || duty == 8'(du))) && k < budget) begin
      cyc();
      k++;
    end
    chk(nm, k < budget, 1);
  endtask

  typedef struct {
    bit [5:0] in;
    int n, st, du, dl, dr;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int cnt, last;
    int q[$];
    int exp_d[4];
    tbl[0] = '{6'b000001, 2, 0, 0, 1, 1};
    tbl[1] = '{6'b100000, 1, 1, 0, 1, 1};
    tbl[2] = '{6'b100000, 3, 1, 50, 1, 1};
    tbl[3] = '{6'b100000, 4, 1, 100, 1, 1};
    tbl[4] = '{6'b100000, 4, 1, 150, 1, 1};
    tbl[5] = '{6'b100000, 4, 1, 200, 1, 1};
    tbl[6] = '{6'b100000, 1, 2, 200, 1, 1};
    tbl[7] = '{6'b000010, 1, 4, 0, 1, 1};
    tbl[8] = '{6'b000000, 2, 4, 0, 1, 1};
    tbl[9] = '{6'b000000, 1, 0, 0, 1, 1};
    exp_d = '{150, 100, 50, 0};
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].in);
      for (int c = 0; c < tbl[i].n; c++) cyc();
      chk($sformatf("tbl%0d", i), {drv_state, duty, dir_l, dir_r},
          {3'(tbl[i].st), 8'(tbl[i].du), 1'(tbl[i].dl), 1'(tbl[i].dr)});
      if (i == 7) chk("stop_pwm_low", pwm_l, 0);
    end
    set_in(6'b100000);
    wait_for("reach_run_fwd", 2, -1, 100);
    cnt = 0;
    for (int c = 0; c < 256; c++) begin
      cyc();
      cnt += int'(pwm_l);
    end
    chk("pwm_high_count", cnt, 200);
    set_in(6'b010000);
    last = 200;
    cnt = 0;
    while (drv_state != 3'd4 && cnt < 100) begin
      cyc();
      cnt++;
      if (int'(duty) != last) begin last = int'(duty); q.push_back(last); end
      if (drv_state != 3'd4) chk("dir_held_down", {dir_l, dir_r}, 2'b11);
    end
    chk("down_seq_len", q.size(), 4);
    foreach (exp_d[i]) if (i < q.size()) chk($sformatf("down_seq%0d", i), q[i], exp_d[i]);
    cnt = 1;
    while (drv_state == 3'd4 && cnt < 20) begin cyc(); if (drv_state == 3'd4) cnt++; end
    chk("dead_len", cnt, 3);
    chk("idle_after_dead", drv_state, 0);
    cyc();
    chk("reverse_up", {drv_state, dir_l, dir_r}, {3'd1, 2'b00});
    set_in(6'b000000);
    wait_for("back_idle", 0, -1, 100);
    set_in(6'b100000);
    wait_for("reach_run_2", 2, -1, 100);
    set_in(6'b101000);
    cyc();
    chk("combo_dead", {drv_state, duty}, {3'd4, 8'd0});
    set_in(6'b000000);
    cyc();
    cyc();
    chk("combo_dead_hold", drv_state, 4);
    cyc();
    chk("combo_idle", drv_state, 0);
    set_in(6'b100000);
    wait_for("reach_run_3", 2, -1, 100);
    set_in(6'b000000);
    wait_for("down_at_100", 3, 100, 100);
    set_in(6'b100000);
    cyc();
    chk("reassert_up", {drv_state, duty}, {3'd1, 8'd100});
    cnt = 0;
    while (duty == 8'd100 && cnt < 10) begin
      cyc();
      cnt++;
      chk("no_dead", drv_state == 3'd4, 0);
    end
    chk("reassert_duty", duty, 150);
    set_in(6'b100001);
    cyc();
    chk("rst_mid_ramp", {drv_state, duty, dir_l, dir_r, pwm_l, pwm_r, busy},
        {3'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    set_in(6'b000000);
    for (int s = 0; s < 200; s++) begin
      int r = $urandom_range(0, 99);
      int hold = $urandom_range(1, 40);
      bit [3:0] c = 4'(1 << $urandom_range(0, 3));
      if (r < 3) begin set_in(6'b000001); hold = 1; end
      else if (r < 10) set_in({4'b0000, 2'b10});
      else if (r < 15) set_in({c | 4'(1 << $urandom_range(0, 3)), 2'b00});
      else if (r < 30) set_in(6'b000000);
      else set_in({c, 2'b00});
      for (int k = 0; k < hold; k++) cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
